// File: rtl/ascii_parse_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ascii_parse_pkg - shared types, character constants, is_term() helper |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package ascii_parse_pkg;

  typedef enum logic [2:0] {IDLE, ZERO, PFX, DIGITS, SKIP, OUT} state_t;
  typedef enum logic [1:0] {DEC = 2'd0, BIN = 2'd1, OCT = 2'd2, HEX = 2'd3} radix_t;

  localparam logic [7:0] c_chr_space = 8'h20;
  localparam logic [7:0] c_chr_tab   = 8'h09;
  localparam logic [7:0] c_chr_cr    = 8'h0D;
  localparam logic [7:0] c_chr_lf    = 8'h0A;
  localparam logic [7:0] c_chr_nul   = 8'h00;

  // Prefix letters are compared after OR-ing in the ASCII case bit.
  localparam logic [7:0] c_case_bit  = 8'h20;
  localparam logic [7:0] c_pfx_hex   = 8'h78;
  localparam logic [7:0] c_pfx_bin   = 8'h62;
  localparam logic [7:0] c_pfx_oct   = 8'h6F;

  function automatic logic is_term(input logic [7:0] ch);
    return (ch == c_chr_space) || (ch == c_chr_tab) || (ch == c_chr_cr) ||
           (ch == c_chr_lf) || (ch == c_chr_nul);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ascii_digit_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ascii_digit_decode - ASCII char to digit value, legality per radix    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module ascii_digit_decode
  import ascii_parse_pkg::*;
(
  input  logic [7:0] ch,
  input  radix_t     radix,
  output logic [3:0] digit,
  output logic       legal
);

  logic [7:0] w_lc;

  always_comb begin
    w_lc  = ch | c_case_bit;
    digit = 4'd0;
    legal = 1'b0;
    if ((ch >= 8'h30) && (ch <= 8'h39)) begin
      digit = ch[3:0];
      case (radix)
        BIN:     legal = (ch[3:0] <= 4'd1);
        OCT:     legal = (ch[3:0] <= 4'd7);
        default: legal = 1'b1;
      endcase
    end else if ((radix == HEX) && (w_lc >= 8'h61) && (w_lc <= 8'h66)) begin
      // 'a'..'f' have low nibbles 1..6, so +9 yields 10..15.
      digit = w_lc[3:0] + 4'd9;
      legal = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ascii_num_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ascii_num_parser - streaming ASCII dec/bin/oct/hex token to integer   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module ascii_num_parser
  import ascii_parse_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_char,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_value,
  output logic [1:0]       out_radix,
  output logic             out_ovf,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int ACC_W = WIDTH + 4;

  state_t           r_state;
  radix_t           r_radix;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;

  logic [3:0]       w_digit;
  logic             w_legal;
  logic [7:0]       w_lc;
  logic             w_is_term;
  logic             w_char_fire;
  logic             w_res_fire;
  logic [ACC_W-1:0] w_acc_scaled;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_acc_ovf;
  logic             w_err;
  logic [WIDTH-1:0] w_res_value;

  // r_radix stays DEC in IDLE/ZERO, so one decoder serves every state.
  ascii_digit_decode u_digit_decode (
    .ch    (in_char),
    .radix (r_radix),
    .digit (w_digit),
    .legal (w_legal)
  );

  assign w_lc        = in_char | c_case_bit;
  assign w_is_term   = is_term(in_char);
  assign w_char_fire = in_valid && in_ready;
  assign w_res_fire  = out_valid && out_ready;

  // The accumulator is below 2**WIDTH whenever it is updated, so the
  // four guard bits always hold acc*16+15 without wrapping.
  always_comb begin
    case (r_radix)
      BIN:     w_acc_scaled = r_acc << 1;
      OCT:     w_acc_scaled = r_acc << 3;
      HEX:     w_acc_scaled = r_acc << 4;
      default: w_acc_scaled = (r_acc << 3) + (r_acc << 1);
    endcase
    w_acc_next = w_acc_scaled + {{(ACC_W-4){1'b0}}, w_digit};
    w_acc_ovf  = |w_acc_next[ACC_W-1:WIDTH];
  end

  assign w_err       = (r_state == PFX) || (r_state == SKIP);
  assign w_res_value = w_err ? '0 : (r_ovf ? '1 : r_acc[WIDTH-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_radix   <= DEC;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_value <= '0;
      out_radix <= 2'd0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else if (r_state == OUT) begin
      if (w_res_fire) begin
        r_state   <= IDLE;
        r_radix   <= DEC;
        r_acc     <= '0;
        r_ovf     <= 1'b0;
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
      end
    end else if (w_char_fire) begin
      if (w_is_term) begin
        if (r_state != IDLE) begin
          r_state   <= OUT;
          in_ready  <= 1'b0;
          out_valid <= 1'b1;
          out_value <= w_res_value;
          out_radix <= r_radix;
          out_ovf   <= r_ovf && !w_err;
          out_err   <= w_err;
        end
      end else begin
        case (r_state)
          IDLE: begin
            if (w_legal) begin
              r_acc   <= w_acc_next;
              r_ovf   <= w_acc_ovf;
              r_state <= (w_digit == 4'd0) ? ZERO : DIGITS;
            end else begin
              r_state <= SKIP;
            end
          end
          ZERO: begin
            if (w_legal) begin
              r_acc   <= w_acc_next;
              r_ovf   <= w_acc_ovf;
              r_state <= DIGITS;
            end else if (w_lc == c_pfx_hex) begin
              r_radix <= HEX;
              r_state <= PFX;
            end else if (w_lc == c_pfx_bin) begin
              r_radix <= BIN;
              r_state <= PFX;
            end else if (w_lc == c_pfx_oct) begin
              r_radix <= OCT;
              r_state <= PFX;
            end else begin
              r_state <= SKIP;
            end
          end
          PFX: begin
            if (w_legal) begin
              r_acc   <= w_acc_next;
              r_ovf   <= w_acc_ovf;
              r_state <= DIGITS;
            end else begin
              r_state <= SKIP;
            end
          end
          DIGITS: begin
            if (w_legal) begin
              if (!r_ovf) begin
                r_acc <= w_acc_next;
                r_ovf <= w_acc_ovf;
              end
            end else begin
              r_state <= SKIP;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ascii_num_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ascii_num_parser - directed self-checking bench, WIDTH=8           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_ascii_num_parser;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [7:0] value;
    logic [1:0] radix;
    logic       ovf;
    logic       err;
  } res_t;

  logic             clk;
  logic             rst_n;
  logic [7:0]       in_char;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_value;
  logic [1:0]       out_radix;
  logic             out_ovf;
  logic             out_err;
  logic             out_valid;
  logic             out_ready;

  int   n_checks = 0;
  int   n_errors = 0;
  res_t q_res[$];
  logic sender_done;

  ascii_num_parser #(.WIDTH(WIDTH)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_char   (in_char),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_value (out_value),
    .out_radix (out_radix),
    .out_ovf   (out_ovf),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture each result transfer just before the rising edge that completes it.
  always begin
    @(negedge clk);
    #4;
    if (rst_n && out_valid && out_ready)
      q_res.push_back('{value: out_value, radix: out_radix, ovf: out_ovf, err: out_err});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    int n = 0;
    in_char  = c;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq("send_timeout", 32'd0, 32'd1);
    else @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic expect_result(input string tag, input logic [7:0] value,
                               input logic [1:0] radix, input logic ovf, input logic err);
    int   n = 0;
    res_t r;
    while (q_res.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q_res.size() == 0) begin
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      r = q_res.pop_front();
      check_eq({tag, "_value"}, {24'd0, r.value}, {24'd0, value});
      check_eq({tag, "_radix"}, {30'd0, r.radix}, {30'd0, radix});
      check_eq({tag, "_ovf"},   {31'd0, r.ovf},   {31'd0, ovf});
      check_eq({tag, "_err"},   {31'd0, r.err},   {31'd0, err});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
    check_eq({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_out_value"}, {24'd0, out_value}, 32'd0);
    check_eq({tag, "_out_radix"}, {30'd0, out_radix}, 32'd0);
    check_eq({tag, "_out_ovf"},   {31'd0, out_ovf},   32'd0);
    check_eq({tag, "_out_err"},   {31'd0, out_err},   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    in_char     = 8'h00;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    sender_done = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // 1: decimal max value, result one cycle after the terminator
    send_str("255 ");
    check_eq("lat_out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("lat_in_ready",  {31'd0, in_ready},  32'd0);
    expect_result("dec255", 8'hFF, 2'd0, 1'b0, 1'b0);

    // 2: prefixed radices, mixed case, lone zero
    send_str("0x1A\n");
    expect_result("hex1a", 8'h1A, 2'd3, 1'b0, 1'b0);
    send_str("0B101 ");
    expect_result("bin101", 8'h05, 2'd1, 1'b0, 1'b0);
    send_str("0 ");
    expect_result("zero", 8'h00, 2'd0, 1'b0, 1'b0);
    send_str("0xfF ");
    expect_result("hexff", 8'hFF, 2'd3, 1'b0, 1'b0);

    // 3: overflow saturates to all ones
    send_str("256 ");
    expect_result("dec256", 8'hFF, 2'd0, 1'b1, 1'b0);
    send_str("0x1FF ");
    expect_result("hex1ff", 8'hFF, 2'd3, 1'b1, 1'b0);

    // 4: malformed tokens, then recovery
    send_str("0o19 ");
    expect_result("oct19", 8'h00, 2'd2, 1'b0, 1'b1);
    send_str("0x ");
    expect_result("hexempty", 8'h00, 2'd3, 1'b0, 1'b1);
    send_str("7 ");
    expect_result("dec7", 8'h07, 2'd0, 1'b0, 1'b0);

    // 5: whitespace only yields nothing; back-pressure holds the result
    send_str("  \n\t");
    repeat (4) @(negedge clk);
    check_eq("ws_no_result", q_res.size(), 32'd0);
    check_eq("ws_out_valid", {31'd0, out_valid}, 32'd0);

    out_ready = 1'b0;
    send_str("12 ");
    fork
      begin
        send_str("34 ");
        sender_done = 1'b1;
      end
    join_none
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_in_ready",  {31'd0, in_ready},  32'd0);
      check_eq("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("stall_out_value", {24'd0, out_value}, 32'd12);
    end
    check_eq("stall_no_transfer", q_res.size(), 32'd0);
    out_ready = 1'b1;
    expect_result("bp12", 8'd12, 2'd0, 1'b0, 1'b0);
    for (int n = 0; n < 100 && !sender_done; n++) @(negedge clk);
    check_eq("bp_sender_done", {31'd0, sender_done}, 32'd1);
    expect_result("bp34", 8'd34, 2'd0, 1'b0, 1'b0);

    // 6: reset mid-token discards the partial value
    send_str("12");
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst_a");
    @(negedge clk);
    check_reset_outputs("mid_rst_b");
    @(negedge clk);
    rst_n = 1'b1;
    send_str("3 ");
    expect_result("after_rst3", 8'd3, 2'd0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check_eq("after_rst_single", q_res.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
